// File: rtl/write_resp_router_if.sv
// Bus bundle for the write-response router: M1 AW/W observation, per-slave B
// channels, the M1 B channel, and the AW_BUSY hold-off to the address stage.
interface write_resp_router_if;
    localparam int ID_BITS  = 4;
    localparam int IDS_BITS = 8;
    localparam int N_SLAVES = 6;

    logic                               AWVALID_M1;
    logic                               AWREADY_M1;
    logic [ID_BITS-1:0]                 AWID_M1;
    logic [N_SLAVES-1:0]                AWVALID_S;

    logic                               WVALID_M1;
    logic                               WREADY_M1;
    logic                               WLAST_M1;

    logic [N_SLAVES-1:0][IDS_BITS-1:0]  BID_S;
    logic [N_SLAVES-1:0][1:0]           BRESP_S;
    logic [N_SLAVES-1:0]                BVALID_S;
    logic [N_SLAVES-1:0]                BREADY_S;

    logic [ID_BITS-1:0]                 BID_M1;
    logic [1:0]                         BRESP_M1;
    logic                               BVALID_M1;
    logic                               BREADY_M1;

    logic                               AW_BUSY;

    // Router side.
    modport slave (
        input  AWVALID_M1, AWREADY_M1, AWID_M1, AWVALID_S,
        input  WVALID_M1, WREADY_M1, WLAST_M1,
        input  BID_S, BRESP_S, BVALID_S, BREADY_M1,
        output BREADY_S, BID_M1, BRESP_M1, BVALID_M1, AW_BUSY
    );

    // Environment side: M1, the address decoder and the slaves.
    modport master (
        output AWVALID_M1, AWREADY_M1, AWID_M1, AWVALID_S,
        output WVALID_M1, WREADY_M1, WLAST_M1,
        output BID_S, BRESP_S, BVALID_S, BREADY_M1,
        input  BREADY_S, BID_M1, BRESP_M1, BVALID_M1, AW_BUSY
    );
endinterface

// File: rtl/write_resp_router.sv
// AXI B-channel stage for M1's single outstanding write: captures target and ID
// at AW, waits for WLAST, then forwards the selected slave's B or synthesises DECERR.
module write_resp_router (
    input  logic               clk,
    input  logic               rst,
    write_resp_router_if.slave bus
);
    localparam int ID_BITS = 4;

    typedef enum logic [1:0] {IDLE, WDATA, WAIT_B, DEC_RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               dec_q, dec_d;
    logic [ID_BITS-1:0] id_q, id_d;
    logic               busy_q;

    logic               aw_hs;
    logic               w_last_hs;
    logic [2:0]         aw_sel;
    logic               aw_hit;

    assign aw_hs     = bus.AWVALID_M1 & bus.AWREADY_M1;
    assign w_last_hs = bus.WVALID_M1 & bus.WREADY_M1 & bus.WLAST_M1;

    // Lowest asserted AWVALID_Sx wins if the decoder ever flags more than one.
    always_comb begin
        aw_sel = '0;
        aw_hit = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (bus.AWVALID_S[i]) begin
                aw_sel = 3'(i);
                aw_hit = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        sel_d         = sel_q;
        dec_d         = dec_q;
        id_d          = id_q;
        bus.BVALID_M1 = 1'b0;
        bus.BRESP_M1  = 2'b00;
        bus.BID_M1    = '0;
        bus.BREADY_S  = '0;

        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d    = bus.AWID_M1;
                    sel_d   = aw_sel;
                    dec_d   = ~aw_hit;
                    state_d = WDATA;
                end
            end
            WDATA: begin
                if (w_last_hs)
                    state_d = dec_q ? DEC_RESP : WAIT_B;
            end
            WAIT_B: begin
                // Only the captured slave is ever allowed to complete its response.
                bus.BVALID_M1       = bus.BVALID_S[sel_q];
                bus.BRESP_M1        = bus.BRESP_S[sel_q];
                bus.BID_M1          = id_q;
                bus.BREADY_S[sel_q] = bus.BREADY_M1;
                if (bus.BVALID_S[sel_q] && bus.BREADY_M1)
                    state_d = IDLE;
            end
            DEC_RESP: begin
                bus.BVALID_M1 = 1'b1;
                bus.BRESP_M1  = 2'b11;
                bus.BID_M1    = id_q;
                if (bus.BREADY_M1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            dec_q   <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            sel_q   <= sel_d;
            dec_q   <= dec_d;
            id_q    <= id_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.AW_BUSY = busy_q;

endmodule

// File: tb/tb_write_resp_router.sv
// Self-checking bench for write_resp_router: directed scenarios plus random writes,
// checked every cycle against a transaction-level model of the outstanding write.
module tb_write_resp_router;
    logic clk;
    logic rst;

    write_resp_router_if bus ();

    write_resp_router dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    m1_b_count;
    string phase;

    // Model of the one outstanding write: who it targets, its ID, whether WLAST has been seen.
    bit       mdl_active;
    bit       mdl_done;
    int       mdl_target;
    bit [3:0] mdl_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [5:0] m);
        for (int i = 0; i < 6; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        logic       e_bvalid;
        logic [1:0] e_bresp;
        logic [3:0] e_bid;
        logic [5:0] e_bready;
        e_bvalid = 1'b0;
        e_bresp  = 2'b00;
        e_bid    = 4'h0;
        e_bready = 6'b0;
        if (mdl_active && mdl_done) begin
            e_bid = mdl_id;
            if (mdl_target < 0) begin
                e_bvalid = 1'b1;
                e_bresp  = 2'b11;
            end else begin
                e_bvalid = bus.BVALID_S[mdl_target];
                e_bresp  = bus.BRESP_S[mdl_target];
                e_bready[mdl_target] = bus.BREADY_M1;
            end
        end
        chk({phase, ":BVALID_M1"}, 32'(bus.BVALID_M1), 32'(e_bvalid));
        chk({phase, ":BRESP_M1"},  32'(bus.BRESP_M1),  32'(e_bresp));
        chk({phase, ":BID_M1"},    32'(bus.BID_M1),    32'(e_bid));
        chk({phase, ":BREADY_S"},  32'(bus.BREADY_S),  32'(e_bready));
        chk({phase, ":AW_BUSY"},   32'(bus.AW_BUSY),   32'(mdl_active));
    endtask

    task automatic model_update();
        if (!mdl_active) begin
            if (bus.AWVALID_M1 && bus.AWREADY_M1) begin
                mdl_active = 1'b1;
                mdl_done   = 1'b0;
                mdl_id     = bus.AWID_M1;
                mdl_target = lowest(bus.AWVALID_S);
            end
        end else if (!mdl_done) begin
            if (bus.WVALID_M1 && bus.WREADY_M1 && bus.WLAST_M1)
                mdl_done = 1'b1;
        end else if (mdl_target < 0) begin
            if (bus.BREADY_M1) mdl_active = 1'b0;
        end else if (bus.BVALID_S[mdl_target] && bus.BREADY_M1) begin
            mdl_active = 1'b0;
        end
    endtask

    // One clock: check on the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (bus.BVALID_M1 && bus.BREADY_M1) m1_b_count++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.AWVALID_M1 = 1'b0;
        bus.AWREADY_M1 = 1'b0;
        bus.AWID_M1    = 4'h0;
        bus.AWVALID_S  = 6'b0;
        bus.WVALID_M1  = 1'b0;
        bus.WREADY_M1  = 1'b0;
        bus.WLAST_M1   = 1'b0;
        bus.BID_S      = '0;
        bus.BRESP_S    = '0;
        bus.BVALID_S   = 6'b0;
        bus.BREADY_M1  = 1'b0;
    endtask

    task automatic aw_phase(input logic [5:0] mask, input logic [3:0] id, input bit early,
                            input bit w_with_aw, input int aw_wait);
        int t;
        t = lowest(mask);
        bus.AWVALID_M1 = 1'b1;
        bus.AWID_M1    = id;
        bus.AWVALID_S  = mask;
        if (early && t >= 0) begin
            bus.BVALID_S[t] = 1'b1;
            bus.BRESP_S[t]  = 2'(($urandom_range(0, 1)));
            bus.BID_S[t]    = {4'h0, id};
        end
        bus.AWREADY_M1 = 1'b0;
        for (int i = 0; i < aw_wait; i++) tick();
        bus.AWREADY_M1 = 1'b1;
        if (w_with_aw) begin
            bus.WVALID_M1 = 1'b1;
            bus.WREADY_M1 = 1'b1;
            bus.WLAST_M1  = 1'b1;
        end
        tick();
        bus.AWVALID_M1 = 1'b0;
        bus.AWREADY_M1 = 1'b0;
        bus.AWVALID_S  = 6'b0;
        bus.WVALID_M1  = 1'b0;
        bus.WREADY_M1  = 1'b0;
        bus.WLAST_M1   = 1'b0;
    endtask

    task automatic w_phase(input int beats, input int stall_max);
        for (int b = 0; b < beats; b++) begin
            int stalls;
            stalls = $urandom_range(0, stall_max);
            bus.WVALID_M1 = 1'b1;
            bus.WLAST_M1  = (b == beats - 1);
            bus.WREADY_M1 = 1'b0;
            for (int s = 0; s < stalls; s++) tick();
            bus.WREADY_M1 = 1'b1;
            tick();
        end
        bus.WVALID_M1 = 1'b0;
        bus.WREADY_M1 = 1'b0;
        bus.WLAST_M1  = 1'b0;
    endtask

    task automatic b_phase(input int t, input logic [3:0] id, input logic [1:0] resp,
                           input int b_delay, input int bready_delay, input int noise);
        if (noise >= 0) begin
            bus.BVALID_S[noise] = 1'b1;
            bus.BRESP_S[noise]  = 2'(($urandom_range(0, 3)));
            bus.BID_S[noise]    = 8'($urandom_range(0, 255));
        end
        for (int c = 0; c < 64 && mdl_active; c++) begin
            if (t >= 0 && (bus.BVALID_S[t] || c >= b_delay)) begin
                if (!bus.BVALID_S[t]) bus.BRESP_S[t] = resp;
                bus.BVALID_S[t] = 1'b1;
                bus.BID_S[t]    = {4'h0, id};
            end
            bus.BREADY_M1 = (c >= bready_delay);
            tick();
        end
        if (mdl_active) chk({phase, ":b_timeout"}, 32'd1, 32'd0);
        if (t >= 0) bus.BVALID_S[t] = 1'b0;
        if (noise >= 0) bus.BVALID_S[noise] = 1'b0;
        bus.BREADY_M1 = 1'b0;
    endtask

    task automatic do_write(input string name, input logic [5:0] mask, input logic [3:0] id,
                            input int beats, input int b_delay, input int bready_delay,
                            input bit early, input int noise, input bit w_with_aw,
                            input int stall_max, input int aw_wait);
        phase      = name;
        m1_b_count = 0;
        aw_phase(mask, id, early, w_with_aw, aw_wait);
        w_phase(beats, stall_max);
        b_phase(lowest(mask), id, 2'(($urandom_range(0, 3))), b_delay, bready_delay, noise);
        chk({name, ":b_count"}, 32'(m1_b_count), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        mdl_active = 1'b0;
        mdl_done   = 1'b0;
        mdl_target = -1;
        mdl_id     = 4'h0;
        phase      = "reset";
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_write("mapped_s2",     6'b000100, 4'h5, 1, 0, 0, 1'b0, -1, 1'b0, 0, 0);
        do_write("burst_s1",      6'b000010, 4'h3, 4, 0, 0, 1'b1, -1, 1'b0, 0, 0);
        do_write("unmapped",      6'b000000, 4'hA, 1, 0, 3, 1'b0, -1, 1'b0, 0, 0);
        do_write("wrong_slave",   6'b000001, 4'h7, 2, 2, 0, 1'b0,  5, 1'b0, 0, 0);

        // Reset while a response from S3 is being presented.
        phase = "rst_mid";
        aw_phase(6'b001000, 4'hC, 1'b0, 1'b0, 0);
        w_phase(3, 0);
        bus.BVALID_S[3] = 1'b1;
        bus.BRESP_S[3]  = 2'b01;
        bus.BID_S[3]    = 8'h0C;
        bus.BREADY_M1   = 1'b1;
        #2;
        check_outputs();
        rst = 1'b0;
        mdl_active = 1'b0;
        mdl_done   = 1'b0;
        #1;
        phase = "rst_async";
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        bus.BVALID_S[3] = 1'b0;
        bus.BREADY_M1   = 1'b0;
        rst = 1'b1;
        do_write("after_rst_s4",  6'b010000, 4'h9, 2, 1, 0, 1'b0, -1, 1'b0, 0, 0);

        // Back-to-back: each call issues AW in the cycle right after the previous B handshake.
        do_write("b2b_first",     6'b100000, 4'h1, 1, 0, 0, 1'b0, -1, 1'b0, 0, 0);
        do_write("b2b_second",    6'b000001, 4'h2, 1, 0, 0, 1'b0, -1, 1'b0, 0, 0);
        do_write("multi_aw",      6'b101000, 4'hE, 2, 0, 1, 1'b0, -1, 1'b0, 0, 0);
        do_write("w_with_aw",     6'b000010, 4'h6, 2, 0, 0, 1'b0, -1, 1'b1, 0, 0);
        do_write("unmapped_b2b",  6'b000000, 4'hF, 3, 0, 0, 1'b0, -1, 1'b0, 1, 1);

        for (int n = 0; n < 40; n++) begin
            int         r;
            int         noise;
            logic [5:0] mask;
            r     = $urandom_range(0, 6);
            mask  = (r == 6) ? 6'b0 : 6'(1 << r);
            noise = -1;
            if ($urandom_range(0, 1) == 1) begin
                noise = $urandom_range(0, 5);
                if (noise == r) noise = -1;
            end
            do_write($sformatf("rand%0d", n), mask, 4'($urandom_range(0, 15)),
                     $urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), noise, 1'b0, 2, $urandom_range(0, 2));
        end

        phase = "final_idle";
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
